// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: bus widths, command encodings, controller and
// write-queue state codes, and the write-queue entry payload.
package sdram_pkg;

  localparam int unsigned ADDR_W        = 22;
  localparam int unsigned DATA_W        = 16;
  localparam int unsigned ROW_LSB       = 8;
  localparam int unsigned MASK_W        = 2;
  localparam int unsigned WQ_DEPTH_LOG2 = 4;

  // SDRAM command triplets {ras_n, cas_n, we_n}
  localparam logic [2:0] CMD_LMR       = 3'b000;
  localparam logic [2:0] CMD_REFRESH   = 3'b001;
  localparam logic [2:0] CMD_PRECHARGE = 3'b010;
  localparam logic [2:0] CMD_ACTIVE    = 3'b011;
  localparam logic [2:0] CMD_WRITE     = 3'b100;
  localparam logic [2:0] CMD_READ      = 3'b101;
  localparam logic [2:0] CMD_NOP       = 3'b111;

  // Controller state codes; the queue offers writes only in SDRAM_WAIT
  typedef enum logic [2:0] {
    SDRAM_INIT,
    SDRAM_WAIT,
    SDRAM_ACTIVATE,
    SDRAM_WRITE,
    SDRAM_READ,
    SDRAM_PRECHARGE,
    SDRAM_REFRESH
  } ctrl_state_e;

  typedef enum logic [1:0] {
    WQ_EMPTY,
    WQ_IDLE,
    WQ_OFFER
  } wq_state_e;

  // One buffered host write
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [MASK_W-1:0] mask;
  } wq_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO storage with registered level and not-full flag.
// Ports: clock, reset (sync, active-high), push/wdata (ignored when full),
// pop (ignored when empty), head_c/next_c (combinational view of the head
// and head+1 slots), level (entries stored), ready (registered not-full).
module sync_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned WIDTH      = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head_c,
  output logic [WIDTH-1:0]      next_c,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  ready
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned LW    = DEPTH_LOG2 + 1;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr, rd_ptr_inc;
  logic                  do_push, do_pop;
  logic [LW-1:0]         level_nxt;

  // Gate requests with the flags and work out the next fill level
  always_comb begin
    do_push   = push && ready;
    do_pop    = pop && (level != '0);
    level_nxt = level;
    if (do_push && !do_pop) begin
      level_nxt = level + LW'(1);
    end else if (!do_push && do_pop) begin
      level_nxt = level - LW'(1);
    end
  end

  assign rd_ptr_inc = rd_ptr + DEPTH_LOG2'(1);

  // Pointers wrap naturally at DEPTH; full/empty come from level only
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ready  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (do_pop)  rd_ptr <= rd_ptr_inc;
      level <= level_nxt;
      ready <= (level_nxt != LW'(DEPTH));
    end
  end

  // Storage carries no reset; contents are only read below level
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign head_c = mem[rd_ptr];
  assign next_c = mem[rd_ptr_inc];

endmodule

// File: rtl/sdram_write_queue.sv
// Write-side front end of the SDRAM controller: buffers host writes and
// offers them one at a time during the controller's WAIT window, flagging
// when the following entry hits the same SDRAM row.
// Ports: clock, reset (sync, active-high); host side wr_req/wr_addr/wr_data/
// wr_mask, wr_ready, level, overflow (sticky); controller side win, q_valid,
// q_addr/q_data/q_mask, q_same_row, q_ack.
module sdram_write_queue
  import sdram_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = WQ_DEPTH_LOG2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                wr_req,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [MASK_W-1:0]   wr_mask,
  output logic                wr_ready,
  output logic [DEPTH_LOG2:0] level,
  output logic                overflow,
  input  logic                win,
  output logic                q_valid,
  output logic [ADDR_W-1:0]   q_addr,
  output logic [DATA_W-1:0]   q_data,
  output logic [MASK_W-1:0]   q_mask,
  output logic                q_same_row,
  input  logic                q_ack
);

  localparam int unsigned LW = DEPTH_LOG2 + 1;

  wq_state_e state, state_nxt;
  wq_entry_t wr_entry, head_c, next_c;
  logic      push_c, pop_c, load_c, same_row_c;

  assign wr_entry = '{addr: wr_addr, data: wr_data, mask: wr_mask};
  assign push_c   = wr_req && wr_ready;

  sync_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      ($bits(wq_entry_t))
  ) u_fifo (
    .clock  (clock),
    .reset  (reset),
    .push   (push_c),
    .wdata  (wr_entry),
    .pop    (pop_c),
    .head_c (head_c),
    .next_c (next_c),
    .level  (level),
    .ready  (wr_ready)
  );

  // Row match between head and head+1, only meaningful with two entries
  assign same_row_c = (level >= LW'(2)) &&
                      (head_c.addr[ADDR_W-1:ROW_LSB] == next_c.addr[ADDR_W-1:ROW_LSB]);

  // Next state; load_c fills the output register, pop_c retires the head.
  // OFFER with q_valid low is the one-cycle reload slot after an ack.
  always_comb begin
    state_nxt = state;
    load_c    = 1'b0;
    pop_c     = 1'b0;
    case (state)
      WQ_EMPTY: begin
        if (level != '0 || push_c) state_nxt = WQ_IDLE;
      end
      WQ_IDLE: begin
        if (win) begin
          state_nxt = WQ_OFFER;
          load_c    = 1'b1;
        end
      end
      WQ_OFFER: begin
        if (!q_valid) begin
          load_c = 1'b1;
        end else if (q_ack) begin
          pop_c = 1'b1;
          if (level > LW'(1)) state_nxt = win ? WQ_OFFER : WQ_IDLE;
          else                state_nxt = WQ_EMPTY;
        end
      end
      default: state_nxt = WQ_EMPTY;
    endcase
  end

  // State, output register and sticky overflow
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= WQ_EMPTY;
      q_valid    <= 1'b0;
      q_addr     <= '0;
      q_data     <= '0;
      q_mask     <= 2'b11;
      q_same_row <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (wr_req && !wr_ready) overflow <= 1'b1;
      if (load_c) begin
        q_valid    <= 1'b1;
        q_addr     <= head_c.addr;
        q_data     <= head_c.data;
        q_mask     <= head_c.mask;
        q_same_row <= same_row_c;
      end else if (pop_c) begin
        q_valid <= 1'b0;
      end
    end
  end

  // The controller may only ack an offered entry
  ack_needs_valid: assert property (@(posedge clock) disable iff (reset) q_ack |-> q_valid);

endmodule

// File: tb/tb_sdram_write_queue.sv
// Directed bench for sdram_write_queue: latency, fill/overflow, row flag,
// window drop hold, full push+pop, wrap ordering and mid-offer reset.
module tb_sdram_write_queue;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        wr_req = 1'b0;
  logic [21:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [1:0]  wr_mask = '0;
  logic        wr_ready;
  logic [4:0]  level;
  logic        overflow;
  logic        win = 1'b0;
  logic        q_valid;
  logic [21:0] q_addr;
  logic [15:0] q_data;
  logic [1:0]  q_mask;
  logic        q_same_row;
  logic        q_ack = 1'b0;

  int tests = 0;
  int fails = 0;

  sdram_write_queue dut (
    .clock      (clock),
    .reset      (reset),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_mask    (wr_mask),
    .wr_ready   (wr_ready),
    .level      (level),
    .overflow   (overflow),
    .win        (win),
    .q_valid    (q_valid),
    .q_addr     (q_addr),
    .q_data     (q_data),
    .q_mask     (q_mask),
    .q_same_row (q_same_row),
    .q_ack      (q_ack)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [21:0] a, input logic [15:0] d, input logic [1:0] m);
    wr_req = 1'b1; wr_addr = a; wr_data = d; wr_mask = m;
    tick();
    wr_req = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (q_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, ".valid"}, 32'(q_valid), 32'd1);
  endtask

  // Wait for an offer, check its payload, then ack it
  task automatic take(input string tag, input logic [21:0] a, input logic [15:0] d,
                      input logic [1:0] m, input logic sr);
    wait_valid(tag);
    chk({tag, ".addr"}, 32'(q_addr), 32'(a));
    chk({tag, ".data"}, 32'(q_data), 32'(d));
    chk({tag, ".mask"}, 32'(q_mask), 32'(m));
    chk({tag, ".same_row"}, 32'(q_same_row), 32'(sr));
    if (q_valid === 1'b1) begin
      q_ack = 1'b1;
      tick();
      q_ack = 1'b0;
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int np, nq, n;

    // Reset state
    tick(2);
    chk("rst.level", 32'(level), 32'd0);
    chk("rst.wr_ready", 32'(wr_ready), 32'd1);
    chk("rst.overflow", 32'(overflow), 32'd0);
    chk("rst.q_valid", 32'(q_valid), 32'd0);
    chk("rst.q_addr", 32'(q_addr), 32'd0);
    chk("rst.q_data", 32'(q_data), 32'd0);
    chk("rst.q_mask", 32'(q_mask), 32'd3);
    chk("rst.q_same_row", 32'(q_same_row), 32'd0);
    reset = 1'b0;
    tick();

    // 1: single write, two-cycle latency, ack empties the queue
    win = 1'b1;
    push(22'h000100, 16'hABCD, 2'b00);
    chk("t1.valid_c1", 32'(q_valid), 32'd0);
    chk("t1.level_c1", 32'(level), 32'd1);
    tick();
    chk("t1.valid_c2", 32'(q_valid), 32'd1);
    take("t1", 22'h000100, 16'hABCD, 2'b00, 1'b0);
    chk("t1.valid_after", 32'(q_valid), 32'd0);
    chk("t1.level_after", 32'(level), 32'd0);
    tick(3);
    chk("t1.stays_empty", 32'(q_valid), 32'd0);

    // 2: fill to 16, overflow on 17th, drain in order
    win = 1'b0;
    for (int i = 0; i < 16; i++) push(22'(i), 16'h1000 + 16'(i), 2'(i));
    chk("t2.level_full", 32'(level), 32'd16);
    chk("t2.wr_ready_full", 32'(wr_ready), 32'd0);
    chk("t2.overflow_pre", 32'(overflow), 32'd0);
    push(22'h3FFFFF, 16'hDEAD, 2'b00);
    chk("t2.overflow", 32'(overflow), 32'd1);
    chk("t2.level_held", 32'(level), 32'd16);
    win = 1'b1;
    for (int i = 0; i < 16; i++)
      take($sformatf("t2.e%0d", i), 22'(i), 16'h1000 + 16'(i), 2'(i), (i < 15));
    chk("t2.level_drained", 32'(level), 32'd0);
    chk("t2.overflow_sticky", 32'(overflow), 32'd1);
    pulse_reset();
    chk("t2.overflow_cleared", 32'(overflow), 32'd0);

    // 5: push+ack at full rejects push; stream 40 entries through wrap
    win = 1'b0;
    for (int i = 0; i < 16; i++) push(22'(i << 8), 16'h5000 + 16'(i), 2'b01);
    win = 1'b1;
    wait_valid("t5.head");
    chk("t5.head_data", 32'(q_data), 32'h5000);
    wr_req = 1'b1; wr_addr = 22'h3FFFFF; wr_data = 16'hDEAD; wr_mask = 2'b00;
    q_ack = 1'b1;
    tick();
    wr_req = 1'b0; q_ack = 1'b0;
    chk("t5.overflow", 32'(overflow), 32'd1);
    chk("t5.level15", 32'(level), 32'd15);
    chk("t5.wr_ready", 32'(wr_ready), 32'd1);
    np = 16; nq = 1; n = 0;
    while (nq < 40 && n < 400) begin
      wr_req  = (np < 40) && wr_ready;
      wr_addr = 22'(np << 8);
      wr_data = 16'h5000 + 16'(np);
      wr_mask = 2'b01;
      q_ack   = q_valid;
      if (q_valid) begin
        chk($sformatf("t5.data%0d", nq), 32'(q_data), 32'h5000 + 32'(nq));
        chk($sformatf("t5.addr%0d", nq), 32'(q_addr), 32'(nq << 8));
        nq++;
      end
      tick();
      if (wr_req) np++;
      n++;
    end
    wr_req = 1'b0; q_ack = 1'b0;
    chk("t5.drained_all", 32'(nq), 32'd40);
    chk("t5.level_end", 32'(level), 32'd0);
    pulse_reset();

    // 3: row-run flag
    win = 1'b0;
    push(22'h000200, 16'h0001, 2'b00);
    push(22'h0002FF, 16'h0002, 2'b00);
    push(22'h000300, 16'h0003, 2'b00);
    win = 1'b1;
    take("t3.a", 22'h000200, 16'h0001, 2'b00, 1'b1);
    take("t3.b", 22'h0002FF, 16'h0002, 2'b00, 1'b0);
    take("t3.c", 22'h000300, 16'h0003, 2'b00, 1'b0);

    // 4: window drops mid-offer; offer held until ack, then IDLE
    win = 1'b1;
    push(22'h3ABCDE, 16'h1357, 2'b10);
    push(22'h000001, 16'h2468, 2'b01);
    wait_valid("t4.offer");
    win = 1'b0;
    tick(10);
    chk("t4.valid_held", 32'(q_valid), 32'd1);
    chk("t4.addr_held", 32'(q_addr), 32'h3ABCDE);
    chk("t4.data_held", 32'(q_data), 32'h1357);
    chk("t4.mask_held", 32'(q_mask), 32'd2);
    chk("t4.same_row_held", 32'(q_same_row), 32'd0);
    q_ack = 1'b1;
    tick();
    q_ack = 1'b0;
    chk("t4.valid_after_ack", 32'(q_valid), 32'd0);
    tick(3);
    chk("t4.idle_no_offer", 32'(q_valid), 32'd0);
    chk("t4.idle_level", 32'(level), 32'd1);
    win = 1'b1;
    take("t4.next", 22'h000001, 16'h2468, 2'b01, 1'b0);

    // 6: reset during an offer with five entries
    win = 1'b0;
    for (int i = 0; i < 5; i++) push(22'h000400 + 22'(i), 16'h7000 + 16'(i), 2'b00);
    win = 1'b1;
    wait_valid("t6.offer");
    chk("t6.level5", 32'(level), 32'd5);
    pulse_reset();
    chk("t6.q_valid", 32'(q_valid), 32'd0);
    chk("t6.level", 32'(level), 32'd0);
    chk("t6.wr_ready", 32'(wr_ready), 32'd1);
    chk("t6.overflow", 32'(overflow), 32'd0);
    win = 1'b0;
    tick(2);
    chk("t6.stays_empty", 32'(q_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
